bus_arbiter: RTL and testbench

//   Shares the 8-bit CPU bus and its 12-bit control word between the microcode controller
//   (default owner) and an external loader/debug port. Grants the loader only at an

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller, the bus arbiter and the top level:
// arbiter state encoding and the control-word bit positions.
`timescale 1ns/1ps
package cpu_pkg;

    // Bus ownership states; the encoding is also exported on the debug owner port
    typedef enum logic [1:0] {
        ST_CPU      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_LDR      = 2'd2,
        ST_HANDBACK = 2'd3
    } arb_state_t;

    // Control-word bit indices, MSB first: {hlt, pc_inc, ..., adder_en}
    localparam int HLT      = 11;
    localparam int PC_INC   = 10;
    localparam int PC_EN    = 9;
    localparam int MAR_LOAD = 8;
    localparam int MEM_EN   = 7;
    localparam int IR_LOAD  = 6;
    localparam int IR_EN    = 5;
    localparam int A_LOAD   = 4;
    localparam int A_EN     = 3;
    localparam int B_LOAD   = 2;
    localparam int SUB      = 1;
    localparam int ADDER_EN = 0;

endpackage

// File: rtl/bus_arbiter.sv
// Bus arbiter between the microcode controller (default owner) and the external
// loader/debug port. The loader is only granted at an instruction boundary, the
// CPU clock is stalled while the loader owns the bus, a grant is bounded to
// MAX_HOLD cycles, and the CPU gets CPU_QUANTUM whole instructions after every
// handback before the loader can win again.
`timescale 1ns/1ps
module bus_arbiter
    import cpu_pkg::*;
#(
    parameter int              CW_W        = 12,
    parameter int              MAX_HOLD    = 64,
    parameter int              CPU_QUANTUM = 2,
    parameter logic [CW_W-1:0] LDR_MASK    = 12'h3FF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW_W-1:0] cpu_ctrl,
    input  logic            cpu_instr_end,
    input  logic            ldr_req,
    input  logic [CW_W-1:0] ldr_ctrl,
    output logic            ldr_gnt,
    output logic            cpu_stall,
    output logic [CW_W-1:0] ctrl_out,
    output logic            timeout_err,
    output logic [1:0]      owner
);

    // MAX_HOLD >= 2 keeps HOLD_W >= 1; a zero quantum still needs a 1-bit counter
    localparam int HOLD_W  = $clog2(MAX_HOLD);
    localparam int QUANT_W = (CPU_QUANTUM > 0) ? $clog2(CPU_QUANTUM + 1) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(MAX_HOLD - 1);
    localparam logic [QUANT_W-1:0] QUANT_RELOAD = QUANT_W'(CPU_QUANTUM);

    arb_state_t         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [QUANT_W-1:0] quantum_cnt;
    logic               rearm;
    logic               cpu_halted;

    // A halted CPU sits permanently at an instruction boundary
    assign cpu_halted = cpu_ctrl[HLT];

    // Ownership FSM together with the hold/quantum counters and the timeout flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_CPU;
            hold_cnt    <= '0;
            quantum_cnt <= '0;
            timeout_err <= 1'b0;
            rearm       <= 1'b1;
        end else begin
            case (state)
                ST_CPU: begin
                    if (cpu_instr_end && (quantum_cnt != '0)) begin
                        quantum_cnt <= quantum_cnt - 1'b1;
                    end
                    if (ldr_req && rearm && ((quantum_cnt == '0) || cpu_halted)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!ldr_req) begin
                        state <= ST_CPU;
                    end else if (cpu_instr_end || cpu_halted) begin
                        state <= ST_LDR;
                    end
                end
                ST_LDR: begin
                    if (!ldr_req) begin
                        state <= ST_HANDBACK;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_HANDBACK;
                        timeout_err <= 1'b1;
                        rearm       <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_HANDBACK: begin
                    hold_cnt    <= '0;
                    quantum_cnt <= QUANT_RELOAD;
                    state       <= ST_CPU;
                end
                default: begin
                    state <= ST_CPU;
                end
            endcase
            // A timed-out loader must show one idle request cycle before it can win again
            if (!ldr_req) begin
                rearm <= 1'b1;
            end
        end
    end

    // Grant, stall and debug owner come straight from the registered state
    assign ldr_gnt   = (state == ST_LDR);
    assign cpu_stall = (state == ST_LDR) || (state == ST_HANDBACK);
    assign owner     = state;

    // Control-word source select; the turnaround cycle drives nothing
    always_comb begin
        ctrl_out = cpu_ctrl;
        case (state)
            ST_LDR:      ctrl_out = ldr_ctrl & LDR_MASK;
            ST_HANDBACK: ctrl_out = '0;
            default:     ctrl_out = cpu_ctrl;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a hand-derived vector table, two
// hand-written multi-cycle sequences (timeout, async reset mid-grant) and a
// randomized run against a behavioural reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int MAX_HOLD    = 64;
    localparam int CPU_QUANTUM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cpu_ctrl;
    logic        cpu_instr_end;
    logic        ldr_req;
    logic [11:0] ldr_ctrl;
    logic        ldr_gnt;
    logic        cpu_stall;
    logic [11:0] ctrl_out;
    logic        timeout_err;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_ctrl     (cpu_ctrl),
        .cpu_instr_end(cpu_instr_end),
        .ldr_req      (ldr_req),
        .ldr_ctrl     (ldr_ctrl),
        .ldr_gnt      (ldr_gnt),
        .cpu_stall    (cpu_stall),
        .ctrl_out     (ctrl_out),
        .timeout_err  (timeout_err),
        .owner        (owner)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        ie;
        logic [11:0] cpu;
        logic [11:0] ldr;
        logic [1:0]  owner;
        logic        gnt;
        logic        stall;
        logic [11:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic req, input logic ie, input logic [11:0] cpu,
                                    input logic [11:0] ldr, input logic [1:0] own,
                                    input logic gnt, input logic stall, input logic [11:0] ctrl);
        vec_t v;
        v.req = req; v.ie = ie; v.cpu = cpu; v.ldr = ldr;
        v.owner = own; v.gnt = gnt; v.stall = stall; v.ctrl = ctrl;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic ie,
                                  input logic [11:0] cpu, input logic [11:0] ldr);
        ldr_req       = req;
        cpu_instr_end = ie;
        cpu_ctrl      = cpu;
        ldr_ctrl      = ldr;
    endtask

    task automatic check_output(input string tag, input logic [1:0] e_owner, input logic e_gnt,
                                input logic e_stall, input logic [11:0] e_ctrl, input logic e_err);
        check({tag, " owner"}, 32'(owner), 32'(e_owner));
        check({tag, " gnt"}, 32'(ldr_gnt), 32'(e_gnt));
        check({tag, " stall"}, 32'(cpu_stall), 32'(e_stall));
        check({tag, " ctrl"}, 32'(ctrl_out), 32'(e_ctrl));
        check({tag, " err"}, 32'(timeout_err), 32'(e_err));
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after it
    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clock_edge();
        clock_edge();
        rst = 1'b1;
    endtask

    // Reference model: who owns the bus, how many instructions the CPU is still
    // owed, how long the current grant has lasted and whether the loader may win
    int m_owner;
    int m_owed;
    int m_granted;
    bit m_err;
    bit m_may_win;

    function automatic void model_reset();
        m_owner   = 0;
        m_owed    = 0;
        m_granted = 0;
        m_err     = 0;
        m_may_win = 1;
    endfunction

    function automatic void model_step(input bit req, input bit ie, input logic [11:0] cpu);
        int nxt;
        bit at_boundary;
        nxt = m_owner;
        at_boundary = ie || cpu[11];
        if (m_owner == 0) begin
            if (req && m_may_win && (m_owed == 0 || cpu[11])) nxt = 1;
            if (ie && m_owed > 0) m_owed = m_owed - 1;
        end else if (m_owner == 1) begin
            if (!req) nxt = 0;
            else if (at_boundary) nxt = 2;
        end else if (m_owner == 2) begin
            m_granted = m_granted + 1;
            if (!req) nxt = 3;
            else if (m_granted == MAX_HOLD) begin
                nxt = 3;
                m_err = 1;
                m_may_win = 0;
            end
        end else begin
            nxt = 0;
            m_granted = 0;
            m_owed = CPU_QUANTUM;
        end
        if (!req) m_may_win = 1;
        m_owner = nxt;
    endfunction

    function automatic logic [11:0] model_ctrl();
        if (m_owner == 2) return ldr_ctrl & 12'h3FF;
        if (m_owner == 3) return 12'h000;
        return cpu_ctrl;
    endfunction

    initial begin
        int gnt_cycles;
        int blocked_gnts;
        bit got_gnt;
        bit req_r;

        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 12'h5A5, 12'h000);
        #2;
        check_output("reset", 2'd0, 1'b0, 1'b0, 12'h5A5, 1'b0);
        clock_edge();
        clock_edge();
        rst = 1'b1;

        // Grant after drain, masked loader word, handback, quantum, halted CPU, req-low priority
        add_vec(0, 0, 12'h5A5, 12'hFFF, 0, 0, 0, 12'h5A5);
        add_vec(0, 0, 12'h5A5, 12'hFFF, 0, 0, 0, 12'h5A5);
        add_vec(1, 0, 12'h123, 12'hFFF, 0, 0, 0, 12'h123);
        add_vec(1, 0, 12'h0A0, 12'hFFF, 1, 0, 0, 12'h0A0);
        add_vec(1, 0, 12'h0A0, 12'hFFF, 1, 0, 0, 12'h0A0);
        add_vec(1, 1, 12'h0A0, 12'hFFF, 1, 0, 0, 12'h0A0);
        add_vec(1, 0, 12'h0A0, 12'hFFF, 2, 1, 1, 12'h3FF);
        add_vec(1, 0, 12'h0A0, 12'hC55, 2, 1, 1, 12'h055);
        add_vec(0, 0, 12'h0A0, 12'h0F0, 2, 1, 1, 12'h0F0);
        add_vec(0, 0, 12'h0A0, 12'h0F0, 3, 0, 1, 12'h000);
        add_vec(1, 0, 12'h111, 12'h0F0, 0, 0, 0, 12'h111);
        add_vec(1, 1, 12'h111, 12'h0F0, 0, 0, 0, 12'h111);
        add_vec(1, 0, 12'h111, 12'h0F0, 0, 0, 0, 12'h111);
        add_vec(1, 1, 12'h111, 12'h0F0, 0, 0, 0, 12'h111);
        add_vec(1, 0, 12'h111, 12'h0F0, 0, 0, 0, 12'h111);
        add_vec(1, 0, 12'h800, 12'h3FF, 1, 0, 0, 12'h800);
        add_vec(1, 0, 12'h800, 12'h3FF, 2, 1, 1, 12'h3FF);
        add_vec(0, 0, 12'h000, 12'h3FF, 2, 1, 1, 12'h3FF);
        add_vec(0, 0, 12'h000, 12'h3FF, 3, 0, 1, 12'h000);
        add_vec(1, 0, 12'h800, 12'h3FF, 0, 0, 0, 12'h800);
        add_vec(0, 1, 12'h800, 12'h3FF, 1, 0, 0, 12'h800);
        add_vec(0, 0, 12'h5A5, 12'h3FF, 0, 0, 0, 12'h5A5);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].req, vecs[i].ie, vecs[i].cpu, vecs[i].ldr);
            #3;
            check_output($sformatf("vec%0d", i), vecs[i].owner, vecs[i].gnt,
                         vecs[i].stall, vecs[i].ctrl, 1'b0);
            clock_edge();
        end

        // Stuck request: grant bounded to MAX_HOLD cycles, then no re-grant while req stays high
        apply_stimulus(1'b0, 1'b0, 12'h000, 12'h2AA);
        do_reset();
        apply_stimulus(1'b1, 1'b1, 12'h000, 12'h2AA);
        clock_edge();
        clock_edge();
        gnt_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(1'b1, 1'b0, 12'h000, 12'h2AA);
            #3;
            if (ldr_gnt) gnt_cycles++;
            else if (gnt_cycles > 0) break;
            clock_edge();
        end
        check("timeout grant length", 32'(gnt_cycles), 32'(MAX_HOLD));
        check("timeout err set", 32'(timeout_err), 32'd1);
        check("timeout handback owner", 32'(owner), 32'd3);
        blocked_gnts = 0;
        for (int i = 0; i < 30; i++) begin
            clock_edge();
            apply_stimulus(1'b1, 1'(i % 2), 12'h000, 12'h2AA);
            #3;
            if (ldr_gnt || owner != 2'd0) blocked_gnts++;
        end
        check("no regrant while req stuck", 32'(blocked_gnts), 32'd0);
        clock_edge();
        apply_stimulus(1'b0, 1'b0, 12'h000, 12'h2AA);
        clock_edge();
        got_gnt = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'(i % 2), 12'h000, 12'h2AA);
            #3;
            if (ldr_gnt) begin
                got_gnt = 1;
                break;
            end
            clock_edge();
        end
        check("regrant after req drop", 32'(got_gnt), 32'd1);
        check("timeout err sticky", 32'(timeout_err), 32'd1);

        // Async reset mid-grant: outputs drop without waiting for a clock edge
        apply_stimulus(1'b1, 1'b0, 12'h5A5, 12'h2AA);
        for (int i = 0; i < 20; i++) clock_edge();
        check("still granted before reset", 32'(ldr_gnt), 32'd1);
        rst = 1'b0;
        #1;
        check_output("async reset", 2'd0, 1'b0, 1'b0, 12'h5A5, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("owner after release", 32'(owner), 32'd0);
        clock_edge();
        check("drain after release", 32'(owner), 32'd1);
        blocked_gnts = 0;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            if (ldr_gnt) blocked_gnts++;
        end
        check("grant waits for instr_end", 32'(blocked_gnts), 32'd0);
        apply_stimulus(1'b1, 1'b1, 12'h5A5, 12'h2AA);
        clock_edge();
        apply_stimulus(1'b1, 1'b0, 12'h5A5, 12'h2AA);
        #3;
        check("grant after instr_end", 32'(ldr_gnt), 32'd1);
        clock_edge();

        // Randomized run against the reference model
        apply_stimulus(1'b0, 1'b0, 12'h000, 12'h000);
        do_reset();
        model_reset();
        req_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) req_r = ~req_r;
            apply_stimulus(req_r, 1'($urandom_range(0, 3) == 0),
                           {1'($urandom_range(0, 15) == 0), 11'($urandom)}, 12'($urandom));
            #3;
            check_output($sformatf("rand%0d", i), 2'(m_owner), 1'(m_owner == 2),
                         1'(m_owner >= 2), model_ctrl(), m_err);
            @(posedge clk);
            model_step(ldr_req, cpu_instr_end, cpu_ctrl);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
